// File: rtl/pc_redirect_ctrl_if.sv
// rtl/pc_redirect_ctrl_if.sv - redirect request / PC control bundle for pc_redirect_ctrl
interface pc_redirect_ctrl_if;
    logic        trap_req;
    logic [31:0] trap_vector;
    logic        mret_req;
    logic [31:0] mepc;
    logic        branch_req;
    logic [31:0] branch_target;
    logic        load_use_stall;
    logic        mdu_busy;
    logic        pc_stall;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        misaligned_exc;
    logic [31:0] misaligned_addr;

    modport master (
        output trap_req, trap_vector, mret_req, mepc, branch_req, branch_target,
               load_use_stall, mdu_busy,
        input  pc_stall, pc_redirect, pc_target, flush_if_id, flush_id_ex,
               misaligned_exc, misaligned_addr
    );

    modport slave (
        input  trap_req, trap_vector, mret_req, mepc, branch_req, branch_target,
               load_use_stall, mdu_busy,
        output pc_stall, pc_redirect, pc_target, flush_if_id, flush_id_ex,
               misaligned_exc, misaligned_addr
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - arbitrates PC redirects against pipeline stalls
module pc_redirect_ctrl #(
    parameter int unsigned TRAP_DRAIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    pc_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, PEND, DRAIN} state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(TRAP_DRAIN);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        pend_trap_q, pend_trap_d;

    logic        stall_in;
    logic [31:0] trap_tgt;
    logic [31:0] cand_tgt;
    logic        cand_misal;
    logic        cand_valid;

    logic        issue;
    logic [31:0] issue_tgt;
    logic        issue_trap;

    logic        pc_stall_c;
    logic        pc_redirect_c;
    logic [31:0] pc_target_c;
    logic        flush_if_id_c;
    logic        flush_id_ex_c;
    logic        misaligned_exc_c;
    logic [31:0] misaligned_addr_c;

    assign stall_in = bus.load_use_stall | bus.mdu_busy;
    assign trap_tgt = {bus.trap_vector[31:2], 2'b00};

    // Trap wins and is always aligned; only mret/branch targets can fault.
    always_comb begin
        cand_tgt = '0;
        if (bus.trap_req) begin
            cand_tgt = trap_tgt;
        end else if (bus.mret_req) begin
            cand_tgt = bus.mepc;
        end else if (bus.branch_req) begin
            cand_tgt = bus.branch_target;
        end
        cand_misal = !bus.trap_req && (bus.mret_req || bus.branch_req)
                     && (cand_tgt[1:0] != 2'b00);
        cand_valid = (bus.trap_req || bus.mret_req || bus.branch_req) && !cand_misal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            pend_tgt_q  <= '0;
            pend_trap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_trap_q <= pend_trap_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        pend_tgt_d        = pend_tgt_q;
        pend_trap_d       = pend_trap_q;
        issue             = 1'b0;
        issue_tgt         = '0;
        issue_trap        = 1'b0;
        pc_stall_c        = 1'b0;
        pc_redirect_c     = 1'b0;
        pc_target_c       = '0;
        flush_if_id_c     = 1'b0;
        flush_id_ex_c     = 1'b0;
        misaligned_exc_c  = 1'b0;
        misaligned_addr_c = '0;

        case (state_q)
            RUN: begin
                if (cand_valid && !stall_in) begin
                    issue      = 1'b1;
                    issue_tgt  = cand_tgt;
                    issue_trap = bus.trap_req;
                end else if (cand_valid) begin
                    state_d       = PEND;
                    pend_tgt_d    = cand_tgt;
                    pend_trap_d   = bus.trap_req;
                    pc_stall_c    = 1'b1;
                    flush_if_id_c = 1'b1;
                end else begin
                    pc_stall_c = stall_in;
                    if (cand_misal) begin
                        misaligned_exc_c  = 1'b1;
                        misaligned_addr_c = cand_tgt;
                    end
                end
            end
            PEND: begin
                // mret/branch seen here come from the wrong path; only a trap replaces the entry.
                if (!stall_in) begin
                    issue      = 1'b1;
                    issue_tgt  = bus.trap_req ? trap_tgt : pend_tgt_q;
                    issue_trap = bus.trap_req | pend_trap_q;
                end else begin
                    pc_stall_c    = 1'b1;
                    flush_if_id_c = 1'b1;
                    if (bus.trap_req) begin
                        pend_tgt_d  = trap_tgt;
                        pend_trap_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (bus.trap_req) begin
                    issue      = 1'b1;
                    issue_tgt  = trap_tgt;
                    issue_trap = 1'b1;
                end else begin
                    pc_stall_c    = 1'b1;
                    flush_if_id_c = 1'b1;
                    cnt_d         = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Common redirect-issue path shared by RUN, PEND release and DRAIN re-trap.
        if (issue) begin
            pc_stall_c    = 1'b0;
            pc_redirect_c = 1'b1;
            pc_target_c   = issue_tgt;
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
            pend_tgt_d    = '0;
            pend_trap_d   = 1'b0;
            if (issue_trap && (DRAIN_LOAD != 4'd0)) begin
                state_d = DRAIN;
                cnt_d   = DRAIN_LOAD;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    // Reset forces every output low, including the pass-through stall.
    assign bus.pc_stall        = pc_stall_c & ~rst;
    assign bus.pc_redirect     = pc_redirect_c & ~rst;
    assign bus.pc_target       = rst ? '0 : pc_target_c;
    assign bus.flush_if_id     = flush_if_id_c & ~rst;
    assign bus.flush_id_ex     = flush_id_ex_c & ~rst;
    assign bus.misaligned_exc  = misaligned_exc_c & ~rst;
    assign bus.misaligned_addr = rst ? '0 : misaligned_addr_c;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [31:0] pc_model;
    logic [31:0] p0;
    logic [4:0]  outs;

    pc_redirect_ctrl_if bus ();

    pc_redirect_ctrl #(.TRAP_DRAIN(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_stall, pc_redirect, flush_if_id, flush_id_ex, misaligned_exc}
    assign outs = {bus.pc_stall, bus.pc_redirect, bus.flush_if_id, bus.flush_id_ex, bus.misaligned_exc};

    // Fetch PC as the PC unit would update it.
    always @(posedge clk or posedge rst) begin
        if (rst) pc_model <= 32'h0;
        else if (bus.pc_redirect) pc_model <= bus.pc_target;
        else if (!bus.pc_stall) pc_model <= pc_model + 32'd4;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic idle();
        bus.trap_req = 1'b0; bus.trap_vector = 32'h0;
        bus.mret_req = 1'b0; bus.mepc = 32'h0;
        bus.branch_req = 1'b0; bus.branch_target = 32'h0;
        bus.load_use_stall = 1'b0; bus.mdu_busy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.mdu_busy = 1'b1; bus.branch_req = 1'b1; bus.branch_target = 32'h100;
        #2;
        n_cmp++; if (outs !== 5'b00000) begin n_err++; $display("FAIL reset_outs: got %b want %b", outs, 5'b00000); end
        n_cmp++; if (bus.pc_target !== 32'h0) begin n_err++; $display("FAIL reset_target: got %h want %h", bus.pc_target, 32'h0); end
        repeat (2) @(negedge clk);
        rst = 1'b0; idle(); #2;
        n_cmp++; if (outs !== 5'b00000) begin n_err++; $display("FAIL reset_release_outs: got %b want %b", outs, 5'b00000); end
        n_cmp++; if (pc_model !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_model, 32'h0); end
    endtask

    task automatic test_branch_nostall();
        @(negedge clk); idle(); bus.branch_req = 1'b1; bus.branch_target = 32'h100; #2;
        n_cmp++; if (outs !== 5'b01110) begin n_err++; $display("FAIL br_outs: got %b want %b", outs, 5'b01110); end
        n_cmp++; if (bus.pc_target !== 32'h100) begin n_err++; $display("FAIL br_target: got %h want %h", bus.pc_target, 32'h100); end
        @(negedge clk); idle(); #2;
        n_cmp++; if (pc_model !== 32'h100) begin n_err++; $display("FAIL br_pc: got %h want %h", pc_model, 32'h100); end
        n_cmp++; if (outs !== 5'b00000) begin n_err++; $display("FAIL br_after_outs: got %b want %b", outs, 5'b00000); end
    endtask

    task automatic test_pend_mdu();
        @(negedge clk); idle(); bus.mdu_busy = 1'b1; bus.branch_req = 1'b1; bus.branch_target = 32'h100; #2;
        p0 = pc_model;
        n_cmp++; if (outs !== 5'b10100) begin n_err++; $display("FAIL pend_c1_outs: got %b want %b", outs, 5'b10100); end
        @(negedge clk); idle(); bus.mdu_busy = 1'b1; bus.branch_req = 1'b1; bus.branch_target = 32'h300; #2;
        n_cmp++; if (outs !== 5'b10100) begin n_err++; $display("FAIL pend_c2_outs: got %b want %b", outs, 5'b10100); end
        n_cmp++; if (pc_model !== p0) begin n_err++; $display("FAIL pend_c2_pc: got %h want %h", pc_model, p0); end
        @(negedge clk); idle(); bus.mdu_busy = 1'b1; #2;
        n_cmp++; if (outs !== 5'b10100) begin n_err++; $display("FAIL pend_c3_outs: got %b want %b", outs, 5'b10100); end
        @(negedge clk); idle(); #2;
        n_cmp++; if (outs !== 5'b01110) begin n_err++; $display("FAIL pend_rel_outs: got %b want %b", outs, 5'b01110); end
        n_cmp++; if (bus.pc_target !== 32'h100) begin n_err++; $display("FAIL pend_rel_target: got %h want %h", bus.pc_target, 32'h100); end
        n_cmp++; if (pc_model !== p0) begin n_err++; $display("FAIL pend_rel_pc: got %h want %h", pc_model, p0); end
        @(negedge clk); idle(); #2;
        n_cmp++; if (pc_model !== 32'h100) begin n_err++; $display("FAIL pend_after_pc: got %h want %h", pc_model, 32'h100); end
        n_cmp++; if (outs !== 5'b00000) begin n_err++; $display("FAIL pend_after_outs: got %b want %b", outs, 5'b00000); end
    endtask

    task automatic test_trap_drain();
        @(negedge clk); idle();
        bus.trap_req = 1'b1; bus.trap_vector = 32'h8000_0003;
        bus.branch_req = 1'b1; bus.branch_target = 32'h44; #2;
        n_cmp++; if (outs !== 5'b01110) begin n_err++; $display("FAIL trap_outs: got %b want %b", outs, 5'b01110); end
        n_cmp++; if (bus.pc_target !== 32'h8000_0000) begin n_err++; $display("FAIL trap_target: got %h want %h", bus.pc_target, 32'h8000_0000); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); #2;
            n_cmp++; if (outs !== 5'b10100) begin n_err++; $display("FAIL trap_drain%0d_outs: got %b want %b", i, outs, 5'b10100); end
            n_cmp++; if (pc_model !== 32'h8000_0000) begin n_err++; $display("FAIL trap_drain%0d_pc: got %h want %h", i, pc_model, 32'h8000_0000); end
        end
        @(negedge clk); idle(); #2;
        n_cmp++; if (outs !== 5'b00000) begin n_err++; $display("FAIL trap_run_outs: got %b want %b", outs, 5'b00000); end
        n_cmp++; if (pc_model !== 32'h8000_0000) begin n_err++; $display("FAIL trap_run_pc: got %h want %h", pc_model, 32'h8000_0000); end
        @(negedge clk); idle(); #2;
        n_cmp++; if (pc_model !== 32'h8000_0004) begin n_err++; $display("FAIL trap_fetch_pc: got %h want %h", pc_model, 32'h8000_0004); end
    endtask

    task automatic test_misaligned();
        @(negedge clk); idle(); bus.mret_req = 1'b1; bus.mepc = 32'h202; #2;
        n_cmp++; if (outs !== 5'b00001) begin n_err++; $display("FAIL mis_outs: got %b want %b", outs, 5'b00001); end
        n_cmp++; if (bus.misaligned_addr !== 32'h202) begin n_err++; $display("FAIL mis_addr: got %h want %h", bus.misaligned_addr, 32'h202); end
        @(negedge clk); idle(); #2;
        n_cmp++; if (outs !== 5'b00000) begin n_err++; $display("FAIL mis_pulse_end: got %b want %b", outs, 5'b00000); end
        bus.trap_req = 1'b1; bus.trap_vector = 32'h500; #1;
        n_cmp++; if (outs !== 5'b01110) begin n_err++; $display("FAIL mis_trap_outs: got %b want %b", outs, 5'b01110); end
        n_cmp++; if (bus.pc_target !== 32'h500) begin n_err++; $display("FAIL mis_trap_target: got %h want %h", bus.pc_target, 32'h500); end
        repeat (3) begin @(negedge clk); idle(); end
    endtask

    task automatic test_pend_overwrite();
        @(negedge clk); idle(); bus.load_use_stall = 1'b1; bus.branch_req = 1'b1; bus.branch_target = 32'h40; #2;
        n_cmp++; if (outs !== 5'b10100) begin n_err++; $display("FAIL ovw_c1_outs: got %b want %b", outs, 5'b10100); end
        @(negedge clk); idle(); bus.load_use_stall = 1'b1; bus.trap_req = 1'b1; bus.trap_vector = 32'h800; #2;
        n_cmp++; if (outs !== 5'b10100) begin n_err++; $display("FAIL ovw_c2_outs: got %b want %b", outs, 5'b10100); end
        @(negedge clk); idle(); #2;
        n_cmp++; if (outs !== 5'b01110) begin n_err++; $display("FAIL ovw_rel_outs: got %b want %b", outs, 5'b01110); end
        n_cmp++; if (bus.pc_target !== 32'h800) begin n_err++; $display("FAIL ovw_rel_target: got %h want %h", bus.pc_target, 32'h800); end
        @(negedge clk); idle(); #2;
        n_cmp++; if (outs !== 5'b10100) begin n_err++; $display("FAIL ovw_drain_outs: got %b want %b", outs, 5'b10100); end
        // Re-trap during drain redirects even while stalled.
        @(negedge clk); idle(); bus.mdu_busy = 1'b1; bus.trap_req = 1'b1; bus.trap_vector = 32'h900; #2;
        n_cmp++; if (outs !== 5'b01110) begin n_err++; $display("FAIL retrap_outs: got %b want %b", outs, 5'b01110); end
        n_cmp++; if (bus.pc_target !== 32'h900) begin n_err++; $display("FAIL retrap_target: got %h want %h", bus.pc_target, 32'h900); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); #2;
            n_cmp++; if (outs !== 5'b10100) begin n_err++; $display("FAIL retrap_drain%0d_outs: got %b want %b", i, outs, 5'b10100); end
        end
        @(negedge clk); idle(); #2;
        n_cmp++; if (outs !== 5'b00000) begin n_err++; $display("FAIL retrap_run_outs: got %b want %b", outs, 5'b00000); end
        n_cmp++; if (pc_model !== 32'h900) begin n_err++; $display("FAIL retrap_pc: got %h want %h", pc_model, 32'h900); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk); idle(); bus.load_use_stall = 1'b1; bus.branch_req = 1'b1; bus.branch_target = 32'h40;
        @(negedge clk); idle(); bus.load_use_stall = 1'b1; rst = 1'b1; #2;
        n_cmp++; if (outs !== 5'b00000) begin n_err++; $display("FAIL rst_pend_outs: got %b want %b", outs, 5'b00000); end
        n_cmp++; if (bus.pc_target !== 32'h0) begin n_err++; $display("FAIL rst_pend_target: got %h want %h", bus.pc_target, 32'h0); end
        @(negedge clk); idle(); rst = 1'b0; #2;
        n_cmp++; if (outs !== 5'b00000) begin n_err++; $display("FAIL rst_pend_rel_outs: got %b want %b", outs, 5'b00000); end
        @(negedge clk); idle(); #2;
        n_cmp++; if (pc_model !== 32'h4) begin n_err++; $display("FAIL rst_pend_pc: got %h want %h", pc_model, 32'h4); end
        bus.trap_req = 1'b1; bus.trap_vector = 32'h600; #1;
        n_cmp++; if (outs !== 5'b01110) begin n_err++; $display("FAIL rst_drain_trap_outs: got %b want %b", outs, 5'b01110); end
        @(negedge clk); idle(); rst = 1'b1; #2;
        n_cmp++; if (outs !== 5'b00000) begin n_err++; $display("FAIL rst_drain_outs: got %b want %b", outs, 5'b00000); end
        @(negedge clk); idle(); rst = 1'b0; #2;
        n_cmp++; if (outs !== 5'b00000) begin n_err++; $display("FAIL rst_drain_rel_outs: got %b want %b", outs, 5'b00000); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_branch_nostall();
        test_pend_mdu();
        test_trap_drain();
        test_misaligned();
        test_pend_overwrite();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
